// File: rtl/nvdla_seq_pkg.sv
// Shared types and helpers for the multiplier fault-injection sequencer.
// Contents: FSM state enum, result-merge function, constant non-zero flags.
// No logic of its own; imported by nvdla_mul_sequencer and its valid pipe.
package nvdla_seq_pkg;

  localparam logic [1:0]  NZ_ALL  = 2'b11;
  localparam int unsigned MERGE_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  // The multiplier returns each product as two partial words.
  // In int8 mode each 16-bit half is an independent lane: no carry crosses lanes.
  function automatic logic [MERGE_W-1:0] merge_res(
    input logic               is_int8,
    input logic [MERGE_W-1:0] a,
    input logic [MERGE_W-1:0] b
  );
    logic [MERGE_W/2-1:0] hi;
    logic [MERGE_W/2-1:0] lo;
    hi = a[MERGE_W-1:MERGE_W/2] + b[MERGE_W-1:MERGE_W/2];
    lo = a[MERGE_W/2-1:0] + b[MERGE_W/2-1:0];
    if (is_int8) begin
      return {hi, lo};
    end
    return a + b;
  endfunction

endpackage

// File: rtl/nvdla_seq_valid_pipe.sv
// Token shift register that tracks multiplier ops in flight.
// Ports: clock/reset, flush (drop all tokens), in_vld (op issued this cycle),
//        out_vld (op result due this cycle), empty (no token anywhere, incl. in_vld).
module nvdla_seq_valid_pipe #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic in_vld,
  output logic out_vld,
  output logic empty
);

  logic [DEPTH-1:0] tok_q;
  logic [DEPTH-1:0] tok_d;

  always_comb begin
    tok_d = {tok_q[DEPTH-2:0], in_vld};
    if (flush) begin
      tok_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tok_q <= '0;
    end else begin
      tok_q <= tok_d;
    end
  end

  assign out_vld = tok_q[DEPTH-1];
  // An op entering this cycle still counts as in flight.
  assign empty   = ~(|tok_q) & ~in_vld;

endmodule

// File: rtl/nvdla_mul_sequencer.sv
// Sequences golden + faulty multiplier copies: config capture, operand stream, result merge.
// Ports: start/cfg_*/num_ops run setup; in_* valid/ready operand source; mul_* to both copies;
//        gm_res_*/fm_res_* results in; out_* merged pair, mismatch flag/count, busy, done.
// Build option NVDLA_SEQ_CMP_EN: enables the golden/faulty comparator and mismatch counter.
module nvdla_mul_sequencer #(
  parameter int unsigned OP_W    = 16,
  parameter int unsigned RES_W   = 32,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned CFG_CYC = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             cfg_int8,
  input  logic             cfg_fp16,
  input  logic [CNT_W-1:0] num_ops,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             mul_cfg_is_int8,
  output logic             mul_cfg_is_fp16,
  output logic             mul_cfg_reg_en,
  output logic [OP_W-1:0]  mul_op_a_dat,
  output logic [OP_W-1:0]  mul_op_b_dat,
  output logic             mul_op_a_pvld,
  output logic             mul_op_b_pvld,
  output logic [1:0]       mul_op_a_nz,
  output logic [1:0]       mul_op_b_nz,
  input  logic [RES_W-1:0] gm_res_a,
  input  logic [RES_W-1:0] gm_res_b,
  input  logic [RES_W-1:0] fm_res_a,
  input  logic [RES_W-1:0] fm_res_b,
  output logic             out_valid,
  output logic [RES_W-1:0] out_golden,
  output logic [RES_W-1:0] out_faulty,
  output logic             out_mismatch,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             busy,
  output logic             done
);
  import nvdla_seq_pkg::*;

  localparam int unsigned CFG_CNT_W = (CFG_CYC > 1) ? $clog2(CFG_CYC) : 1;

  seq_state_e           state_q, state_d;
  logic [CFG_CNT_W-1:0] cfg_cnt_q, cfg_cnt_d;
  logic                 int8_q, int8_d;
  logic                 fp16_q, fp16_d;
  logic [CNT_W-1:0]     num_q, num_d;
  logic [CNT_W-1:0]     issued_q, issued_d;
  logic [OP_W-1:0]      dat_a_q, dat_a_d;
  logic [OP_W-1:0]      dat_b_q, dat_b_d;
  logic                 pvld_q, pvld_d;
  logic                 start_acc;
  logic                 pipe_empty;

  always_comb begin
    state_d        = state_q;
    cfg_cnt_d      = cfg_cnt_q;
    int8_d         = int8_q;
    fp16_d         = fp16_q;
    num_d          = num_q;
    issued_d       = issued_q;
    dat_a_d        = dat_a_q;
    dat_b_d        = dat_b_q;
    pvld_d         = 1'b0;
    start_acc      = 1'b0;
    in_ready       = 1'b0;
    mul_cfg_reg_en = 1'b0;
    done           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          int8_d    = cfg_int8;
          fp16_d    = cfg_fp16;
          num_d     = num_ops;
          issued_d  = '0;
          cfg_cnt_d = '0;
          state_d   = ST_CFG;
        end
      end
      ST_CFG: begin
        mul_cfg_reg_en = 1'b1;
        if (cfg_cnt_q == CFG_CNT_W'(CFG_CYC - 1)) begin
          state_d = (num_q == '0) ? ST_DRAIN : ST_RUN;
        end else begin
          cfg_cnt_d = cfg_cnt_q + CFG_CNT_W'(1);
        end
      end
      ST_RUN: begin
        in_ready = (issued_q < num_q);
        if (in_ready && in_valid) begin
          dat_a_d  = in_a;
          dat_b_d  = in_b;
          pvld_d   = 1'b1;
          issued_d = issued_q + CNT_W'(1);
          if (issued_d == num_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cfg_cnt_q <= '0;
      int8_q    <= 1'b0;
      fp16_q    <= 1'b0;
      num_q     <= '0;
      issued_q  <= '0;
      dat_a_q   <= '0;
      dat_b_q   <= '0;
      pvld_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_cnt_q <= cfg_cnt_d;
      int8_q    <= int8_d;
      fp16_q    <= fp16_d;
      num_q     <= num_d;
      issued_q  <= issued_d;
      dat_a_q   <= dat_a_d;
      dat_b_q   <= dat_b_d;
      pvld_q    <= pvld_d;
    end
  end

  // Tokens enter with pvld, so out_vld lands exactly MUL_LAT cycles after pvld.
  nvdla_seq_valid_pipe #(
    .DEPTH (MUL_LAT)
  ) u_valid_pipe (
    .clock   (clock),
    .reset   (reset),
    .flush   (start_acc),
    .in_vld  (pvld_q),
    .out_vld (out_valid),
    .empty   (pipe_empty)
  );

  assign busy            = (state_q != ST_IDLE);
  assign mul_cfg_is_int8 = int8_q;
  assign mul_cfg_is_fp16 = fp16_q & ~int8_q;
  assign mul_op_a_dat    = dat_a_q;
  assign mul_op_b_dat    = dat_b_q;
  assign mul_op_a_pvld   = pvld_q;
  assign mul_op_b_pvld   = pvld_q;
  assign mul_op_a_nz     = NZ_ALL;
  assign mul_op_b_nz     = NZ_ALL;

  assign out_golden = out_valid ? merge_res(int8_q, gm_res_a, gm_res_b) : '0;
  assign out_faulty = out_valid ? merge_res(int8_q, fm_res_a, fm_res_b) : '0;

`ifdef NVDLA_SEQ_CMP_EN
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  assign out_mismatch = out_valid & (out_golden != out_faulty);

  // No result can be valid in IDLE, so the start clear never races an increment.
  always_comb begin
    mcnt_d = mcnt_q;
    if (start_acc) begin
      mcnt_d = '0;
    end else if (out_mismatch && (mcnt_q != '1)) begin
      mcnt_d = mcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mcnt_q <= '0;
    end else begin
      mcnt_q <= mcnt_d;
    end
  end

  assign mismatch_cnt = mcnt_q;
`else
  assign out_mismatch = 1'b0;
  assign mismatch_cnt = '0;
`endif

endmodule
